// File: rtl/ball_rx_receiver.sv
// ball_rx_receiver: reassembles the 6-byte ball-state frame from the link byte
// stream, verifies the XOR checksum, and holds the decoded ball until the local
// game controller acknowledges the spawn.
//
// Byte strobes (rx_valid) carry no back-pressure: a byte presented while
// rx_valid is high is consumed on that clock edge. ball_spawn_ack is a one-cycle
// pulse; ball_pending stays high from frame acceptance until the edge that
// samples an ack.
module ball_rx_receiver #(
    parameter int         TIMEOUT_CYCLES = 25000,
    parameter logic [7:0] HEADER         = 8'hA5
) (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        ball_spawn_ack,
    output logic [7:0]  ball_vy_rx,
    output logic [1:0]  gravity_counter_rx,
    output logic [7:0]  ball_speed_reg0_rx,
    output logic [7:0]  ball_speed_reg1_rx,
    output logic [3:0]  ball_speed_reg2_rx,
    output logic [19:0] ball_speed_rx,
    output logic        ball_pending,
    output logic        ball_recv_pulse,
    output logic        frame_drop,
    output logic        checksum_err,
    output logic        timeout_err,
    output logic [7:0]  err_count,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter value seen on the edge whose increment would reach TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_VY   = 3'd1,
        GET_GRAV = 3'd2,
        GET_SPD0 = 3'd3,
        GET_SPD1 = 3'd4,
        GET_CHK  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_idle_cnt;

    logic [7:0]    r_sh_vy;
    logic [1:0]    r_sh_grav;
    logic [3:0]    r_sh_reg2;
    logic [7:0]    r_sh_reg0;
    logic [7:0]    r_sh_reg1;
    logic [7:0]    r_xor;

    logic [7:0]    r_vy;
    logic [1:0]    r_grav;
    logic [7:0]    r_reg0;
    logic [7:0]    r_reg1;
    logic [3:0]    r_reg2;
    logic          r_pending;
    logic          r_recv_pulse;
    logic          r_frame_drop;
    logic          r_chk_err;
    logic          r_to_err;
    logic [7:0]    r_err_cnt;

    logic          w_frame_done;
    logic          w_timeout;
    logic          w_chk_ok;
    logic          w_pending_eff;
    logic          w_accept;
    logic          w_drop;
    logic          w_bad;

    // State register
    always_ff @(posedge clk_25MHZ) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode, frame completion and timeout detection
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE:     if (rx_valid && rx_data == HEADER) w_state_next = GET_VY;
            GET_VY:   if (rx_valid) w_state_next = GET_GRAV;
            GET_GRAV: if (rx_valid) w_state_next = GET_SPD0;
            GET_SPD0: if (rx_valid) w_state_next = GET_SPD1;
            GET_SPD1: if (rx_valid) w_state_next = GET_CHK;
            GET_CHK: begin
                if (rx_valid) begin
                    w_state_next = IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default:  w_state_next = IDLE;
        endcase
        // A byte arriving on the expiry cycle wins, so rx_valid blocks the timeout.
        if (r_state != IDLE && !rx_valid && r_idle_cnt == IDLE_LAST) begin
            w_state_next = IDLE;
            w_timeout    = 1'b1;
        end
    end

    // Frame verdict; an ack in the same cycle clears pending before the check.
    assign w_chk_ok      = (rx_data == r_xor);
    assign w_pending_eff = r_pending & ~ball_spawn_ack;
    assign w_accept      = w_frame_done & w_chk_ok & ~w_pending_eff;
    assign w_drop        = w_frame_done & w_chk_ok & w_pending_eff;
    assign w_bad         = w_frame_done & ~w_chk_ok;

    // Inter-byte idle counter, only running inside a frame
    always_ff @(posedge clk_25MHZ) begin
        if (reset || r_state == IDLE || rx_valid || w_timeout) r_idle_cnt <= '0;
        else                                                   r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    // Shadow capture of frame bytes and running checksum over B1..B4
    always_ff @(posedge clk_25MHZ) begin
        if (reset || w_timeout) begin
            r_sh_vy   <= '0;
            r_sh_grav <= '0;
            r_sh_reg2 <= '0;
            r_sh_reg0 <= '0;
            r_sh_reg1 <= '0;
            r_xor     <= '0;
        end else if (rx_valid) begin
            case (r_state)
                GET_VY: begin
                    r_sh_vy <= rx_data;
                    r_xor   <= rx_data;
                end
                GET_GRAV: begin
                    r_sh_grav <= rx_data[1:0];
                    r_sh_reg2 <= rx_data[7:4];
                    r_xor     <= r_xor ^ rx_data;
                end
                GET_SPD0: begin
                    r_sh_reg0 <= rx_data;
                    r_xor     <= r_xor ^ rx_data;
                end
                GET_SPD1: begin
                    r_sh_reg1 <= rx_data;
                    r_xor     <= r_xor ^ rx_data;
                end
                default: ;
            endcase
        end
    end

    // Decoded outputs, pending flag, event pulses and saturating error count
    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            r_vy         <= '0;
            r_grav       <= '0;
            r_reg0       <= '0;
            r_reg1       <= '0;
            r_reg2       <= '0;
            r_pending    <= 1'b0;
            r_recv_pulse <= 1'b0;
            r_frame_drop <= 1'b0;
            r_chk_err    <= 1'b0;
            r_to_err     <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_recv_pulse <= w_accept;
            r_frame_drop <= w_drop;
            r_chk_err    <= w_bad;
            r_to_err     <= w_timeout;
            if (w_accept) begin
                r_vy      <= r_sh_vy;
                r_grav    <= r_sh_grav;
                r_reg2    <= r_sh_reg2;
                r_reg0    <= r_sh_reg0;
                r_reg1    <= r_sh_reg1;
                r_pending <= 1'b1;
            end else if (ball_spawn_ack) begin
                r_pending <= 1'b0;
            end
            if ((w_bad || w_timeout) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ball_vy_rx         = r_vy;
    assign gravity_counter_rx = r_grav;
    assign ball_speed_reg0_rx = r_reg0;
    assign ball_speed_reg1_rx = r_reg1;
    assign ball_speed_reg2_rx = r_reg2;
    assign ball_speed_rx      = {r_reg2, r_reg1, r_reg0};
    assign ball_pending       = r_pending;
    assign ball_recv_pulse    = r_recv_pulse;
    assign frame_drop         = r_frame_drop;
    assign checksum_err       = r_chk_err;
    assign timeout_err        = r_to_err;
    assign err_count          = r_err_cnt;
    assign dbg_state          = r_state;

endmodule

// File: tb/tb_ball_rx_receiver.sv
// tb_ball_rx_receiver: directed test-plan sequences followed by randomized byte
// traffic, with a frame-level reference model feeding an expected-event queue.
module tb_ball_rx_receiver;

    localparam int         TO  = 16;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         W   = 42;

    // ---------------- clock / reset ----------------
    logic        clk_25MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_valid  = 1'b0;
    logic        ball_spawn_ack = 1'b0;
    logic [7:0]  ball_vy_rx;
    logic [1:0]  gravity_counter_rx;
    logic [7:0]  ball_speed_reg0_rx;
    logic [7:0]  ball_speed_reg1_rx;
    logic [3:0]  ball_speed_reg2_rx;
    logic [19:0] ball_speed_rx;
    logic        ball_pending;
    logic        ball_recv_pulse;
    logic        frame_drop;
    logic        checksum_err;
    logic        timeout_err;
    logic [7:0]  err_count;
    logic [2:0]  dbg_state;

    always #20 clk_25MHZ = ~clk_25MHZ;

    int cyc = 0;
    always @(posedge clk_25MHZ) cyc = cyc + 1;

    ball_rx_receiver #(.TIMEOUT_CYCLES(TO), .HEADER(HDR)) dut (
        .clk_25MHZ(clk_25MHZ), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .ball_spawn_ack(ball_spawn_ack), .ball_vy_rx(ball_vy_rx),
        .gravity_counter_rx(gravity_counter_rx), .ball_speed_reg0_rx(ball_speed_reg0_rx),
        .ball_speed_reg1_rx(ball_speed_reg1_rx), .ball_speed_reg2_rx(ball_speed_reg2_rx),
        .ball_speed_rx(ball_speed_rx), .ball_pending(ball_pending),
        .ball_recv_pulse(ball_recv_pulse), .frame_drop(frame_drop),
        .checksum_err(checksum_err), .timeout_err(timeout_err),
        .err_count(err_count), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_in_frame = 0;
    logic [7:0] m_buf[$];
    int         m_idle = 0;
    logic [7:0] m_vy = 0, m_reg0 = 0, m_reg1 = 0, m_err = 0;
    logic [1:0] m_grav = 0;
    logic [3:0] m_reg2 = 0;
    bit         m_pending = 0;

    // event codes: 1 recv, 2 drop, 3 checksum, 4 timeout
    function automatic void push_evt(input logic [2:0] typ);
        exp_q.push_back({typ, m_pending, m_err, m_vy, m_grav, m_reg2, m_reg1, m_reg0});
        exp_cyc_q.push_back(cyc);
    endfunction

    function automatic void bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ack);
        logic [7:0] x;
        if (ack) m_pending = 0;
        m_idle = 0;
        if (!m_in_frame) begin
            if (b == HDR) begin
                m_in_frame = 1;
                m_buf.delete();
            end
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 5) begin
                m_in_frame = 0;
                x = m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3];
                if (x != m_buf[4]) begin
                    bump_err();
                    push_evt(3'd3);
                end else if (m_pending) begin
                    push_evt(3'd2);
                end else begin
                    m_vy = m_buf[0];
                    m_grav = m_buf[1][1:0];
                    m_reg2 = m_buf[1][7:4];
                    m_reg0 = m_buf[2];
                    m_reg1 = m_buf[3];
                    m_pending = 1;
                    push_evt(3'd1);
                end
            end
        end
    endfunction

    function automatic void model_idle();
        if (m_in_frame) begin
            m_idle++;
            if (m_idle == TO - 1) begin
                m_in_frame = 0;
                m_idle = 0;
                bump_err();
                push_evt(3'd4);
            end
        end
    endfunction

    function automatic void model_reset();
        m_in_frame = 0; m_buf.delete(); m_idle = 0;
        m_vy = 0; m_grav = 0; m_reg0 = 0; m_reg1 = 0; m_reg2 = 0;
        m_pending = 0; m_err = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b, input bit ack = 0);
        rx_data = b; rx_valid = 1'b1; ball_spawn_ack = ack;
        @(posedge clk_25MHZ); #1;
        rx_valid = 1'b0; ball_spawn_ack = 1'b0; rx_data = 8'($urandom);
        model_byte(b, ack);
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(posedge clk_25MHZ); #1;
            model_idle();
        end
    endtask

    task automatic ack_only();
        ball_spawn_ack = 1'b1;
        @(posedge clk_25MHZ); #1;
        ball_spawn_ack = 1'b0;
        m_pending = 0;
        model_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_25MHZ); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // xm corrupts the checksum (0 = correct); ack_last pulses ack with B5
    task automatic send_frame(input logic [7:0] vy, input logic [7:0] b2, input logic [7:0] r0,
                              input logic [7:0] r1, input logic [7:0] xm, input bit ack_last,
                              input int gap_max);
        send(HDR);
        stall($urandom_range(0, gap_max));
        send(vy);
        stall($urandom_range(0, gap_max));
        send(b2);
        stall($urandom_range(0, gap_max));
        send(r0);
        stall($urandom_range(0, gap_max));
        send(r1);
        stall($urandom_range(0, gap_max));
        send(vy ^ b2 ^ r0 ^ r1 ^ xm, ack_last);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vy"}, ball_vy_rx, m_vy);
        chk({tag, "_grav"}, gravity_counter_rx, m_grav);
        chk({tag, "_regs"}, {ball_speed_reg2_rx, ball_speed_reg1_rx, ball_speed_reg0_rx},
            {m_reg2, m_reg1, m_reg0});
        chk({tag, "_speed"}, ball_speed_rx, {m_reg2, m_reg1, m_reg0});
        chk({tag, "_pending"}, ball_pending, m_pending);
        chk({tag, "_err_count"}, err_count, m_err);
        if (!m_in_frame) chk({tag, "_fsm_idle"}, dbg_state, 3'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_25MHZ) begin
        int np;
        logic [2:0] typ;
        logic [W-1:0] act;
        logic [W-1:0] e;
        int ec;
        np = int'(ball_recv_pulse) + int'(frame_drop) + int'(checksum_err) + int'(timeout_err);
        if (np > 1) begin
            n_tests++; n_fail++;
            $display("FAIL pulse_overlap: got %b%b%b%b expected one-hot", ball_recv_pulse,
                     frame_drop, checksum_err, timeout_err);
        end else if (np == 1) begin
            typ = ball_recv_pulse ? 3'd1 : frame_drop ? 3'd2 : checksum_err ? 3'd3 : 3'd4;
            act = {typ, ball_pending, err_count, ball_vy_rx, gravity_counter_rx, ball_speed_rx};
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("event", act, e);
                chk("event_cycle", cyc, ec);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk_25MHZ);
        #1 reset = 1'b0;
        model_reset();
        check_outputs("reset");

        // noise, then bad checksum (B5 = 0x00)
        send(8'h00); send(8'hFF);
        send_frame(8'h3C, 8'h52, 8'h10, 8'h27, 8'h59, 0, 0);
        stall(1);
        check_outputs("bad_chk");
        chk("bad_chk_err1", err_count, 8'd1);

        // good frame
        send_frame(8'h3C, 8'h52, 8'h10, 8'h27, 8'h00, 0, 0);
        stall(1);
        check_outputs("good");
        chk("good_speed_const", ball_speed_rx, 20'h52710);
        ack_only();
        stall(1);
        check_outputs("ack");

        // overrun: drop, then ack coincident with B5
        send_frame(8'h3C, 8'h52, 8'h10, 8'h27, 8'h00, 0, 0);
        send_frame(8'h11, 8'h52, 8'h10, 8'h27, 8'h00, 0, 0);
        stall(1);
        check_outputs("drop");
        send_frame(8'h11, 8'h52, 8'h10, 8'h27, 8'h00, 1, 0);
        stall(1);
        check_outputs("ack_b5");
        ack_only();

        // timeout after 15 idle cycles, then a full frame
        send(HDR); send(8'h01);
        stall(16);
        send_frame(8'h21, 8'h93, 8'h44, 8'h55, 8'h00, 0, 1);
        stall(1);
        check_outputs("after_to");
        ack_only();

        // 14-cycle stall mid-frame is tolerated
        send(HDR); send(8'h77); send(8'h41);
        stall(14);
        send(8'h22); send(8'h33); send(8'h77 ^ 8'h41 ^ 8'h22 ^ 8'h33);
        stall(1);
        check_outputs("stall14");
        ack_only();

        // header value as data
        send_frame(HDR, 8'h6F, 8'hA5, 8'h01, 8'h00, 0, 0);
        stall(1);
        check_outputs("vy_hdr");
        ack_only();

        // reset after B3 then full frame
        send(HDR); send(8'h12); send(8'h34); send(8'h56);
        do_reset();
        check_outputs("mid_reset");
        send_frame(8'h9A, 8'hC3, 8'hBC, 8'hDE, 8'h00, 0, 0);
        stall(1);
        check_outputs("post_reset");
        ack_only();

        // saturation
        for (int i = 0; i < 260; i++) send_frame(8'(i), 8'(i * 3), 8'h5A, 8'hC3, 8'h01, 0, 0);
        stall(1);
        check_outputs("sat");
        chk("sat_255", err_count, 8'hFF);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 0, 0);
        stall(1);
        chk("sat_hold", err_count, 8'hFF);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                       ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                                       1'($urandom_range(0, 1)), 2);
                4: send(8'($urandom));
                5, 6: ack_only();
                7: stall($urandom_range(0, 20));
                8: begin
                    send(HDR);
                    repeat ($urandom_range(0, 3)) send(8'($urandom));
                    stall($urandom_range(10, 18));
                end
                default: begin
                    send(8'($urandom), 1'($urandom_range(0, 1)));
                end
            endcase
            if (i % 25 == 0) begin
                stall(1);
                check_outputs("rand");
            end
        end

        stall(TO + 2);
        check_outputs("final");
        chk("leftover_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_rx_receiver.md
# ball_rx_receiver

Receive side of the inter-board ball hand-off link. The block accepts the byte stream produced by the link's byte receiver and reassembles the ball-state frame sent by the opponent board's game controller: vertical velocity, gravity phase, and the 20-bit speed. It checks the frame, holds the decoded ball parameters, and keeps them pending until the local game controller acknowledges that it has spawned the incoming ball.

## Interface
- TIMEOUT_CYCLES, 25000: maximum number of idle cycles allowed between bytes inside a frame (1 ms at 25 MHz).
- HEADER, 8'hA5: frame start byte.
- clk_25MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  single-cycle strobe, one per byte.
- ball_spawn_ack  in  1  single-cycle pulse from the game controller that clears ball_pending.
- ball_vy_rx  out  8  decoded vertical velocity.
- gravity_counter_rx  out  2  decoded gravity phase.
- ball_speed_reg0_rx / ball_speed_reg1_rx  out  8 each  decoded speed bytes.
- ball_speed_reg2_rx  out  4  decoded speed upper nibble.
- ball_speed_rx  out  20  equal to {reg2, reg1, reg0}.
- ball_pending  out  1  a decoded ball is waiting to be spawned.
- ball_recv_pulse  out  1  one-cycle pulse when a good frame is latched.
- frame_drop  out  1  one-cycle pulse when a good frame is discarded because a ball is already pending.
- checksum_err  out  1  one-cycle pulse on a checksum mismatch.
- timeout_err  out  1  one-cycle pulse on an inter-byte timeout.
- err_count  out  8  count of checksum errors plus timeouts; saturates at 255.

## Operation
- Frame format, 6 bytes:
  - B0 = HEADER
  - B1 = vy
  - B2 = {reg2[3:0], 2'b00, gravity[1:0]}
  - B3 = reg0
  - B4 = reg1
  - B5 = B1 ^ B2 ^ B3 ^ B4
- FSM states: IDLE, GET_VY, GET_GRAV, GET_SPD0, GET_SPD1, GET_CHK.
  - IDLE to GET_VY on rx_valid with rx_data == HEADER. All other bytes in IDLE are ignored.
  - Each later state advances on rx_valid and captures its byte into a shadow register. The running XOR covers B1–B4.
  - Inside a frame, a HEADER value is treated as data. There is no mid-frame resync; the timeout is the only recovery path.
  - B2 bits [3:2] are ignored and are not checked.
  - GET_CHK to IDLE on rx_valid:
    - Match and !ball_pending: copy shadows to the outputs, set ball_pending, pulse ball_recv_pulse.
    - Match and ball_pending: outputs are unchanged, pulse frame_drop.
    - Mismatch: outputs are unchanged, pulse checksum_err, err_count += 1.
- Timeout:
  - In any state other than IDLE, the idle counter increments on each cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte: go to IDLE, pulse timeout_err, err_count += 1, discard the shadows.
- Pending clears on ball_spawn_ack. An ack while not pending has no effect.
- Simultaneous ack and good checksum byte in the same cycle: the ack is applied first. The frame is accepted (outputs updated, ball_pending stays 1, ball_recv_pulse asserts) and no frame_drop is generated.
- Simultaneous timeout and rx_valid in the same cycle: rx_valid wins and the byte is processed normally.
- err_count holds at 255.

## Timing
- Reset values: FSM in IDLE; every data output is 0; ball_pending, all pulses and err_count are 0; the idle counter is 0.
- Reset asserted mid-frame aborts the frame on the next edge with no error pulse.
- All outputs are registered.
- Latency: data outputs, ball_pending and ball_recv_pulse all change on the clock edge that samples the B5 strobe. The pulse is high for exactly the following cycle.
- frame_drop, checksum_err and timeout_err are each high for exactly one cycle. They are never asserted together with ball_recv_pulse.
- ball_pending falls on the edge that samples ball_spawn_ack.
- Throughput: back-to-back strobes on consecutive cycles are supported. A new HEADER may arrive on the cycle immediately after B5.
- ball_speed_rx is a combinational concatenation of the registered speed outputs and has no extra latency.

## Test plan
- Good frame: A5, 3C, 52, 10, 27, (3C^52^10^27) → vy = 0x3C, gravity = 2, reg2 = 5, reg0 = 0x10, reg1 = 0x27, ball_speed_rx = 0x52710; one ball_recv_pulse; ball_pending = 1. Then an ack → ball_pending = 0.
- Bad checksum: the same frame with B5 = 0x00 → checksum_err pulses, err_count = 1, outputs remain at reset values, ball_pending = 0.
- Overrun:
  - Second good frame (vy = 0x11) while still pending → frame_drop pulses and vy stays 0x3C.
  - Repeat with the ack in the same cycle as B5 → vy = 0x11 and ball_recv_pulse asserts with no frame_drop.
- Timeout (TIMEOUT_CYCLES = 16): send A5, 01 then stall 16 cycles → timeout_err pulses on the stall's 15th cycle, the FSM returns to IDLE, and a following full frame decodes correctly. A stall of 14 cycles causes no error.
- Noise and resync:
  - Bytes 00, FF before A5 are ignored.
  - A frame with B1 = A5 decodes vy = 0xA5.
  - Reset asserted after B3 followed by a full frame decodes correctly with err_count = 0.
- Saturation: 260 bad frames → err_count = 255 and stays at 255.
